// File: rtl/shift_add_mult8_pkg.sv
// shift_add_mult8_pkg: shared width and FSM encoding for the shift-and-add multiplier
package shift_add_mult8_pkg;
  localparam int WIDTH = 8;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/shift_add_mult8_rca.sv
// RCA16bit: 16-bit ripple-carry adder built from a chain of full adders
module RCA16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  logic [16:0] c;
  assign c[0] = cin;
  genvar i;
  for (i = 0; i < 16; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout = c[16];
endmodule

// File: rtl/shift_add_mult8.sv
// shift_add_mult8: sequential unsigned 8x8->16 multiplier, one partial-product add per cycle
module shift_add_mult8
  import shift_add_mult8_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] product
);
  state_t state, state_nx;
  logic [15:0] acc, mcand, pp, sum;
  logic [7:0] mplier;
  logic [CW-1:0] count;
  RCA16bit u_rca (.a(acc), .b(pp), .cin(1'b0), .sum(sum), .cout());
  always_comb begin
    pp = mplier[0] ? mcand : 16'd0;
    in_ready = state == IDLE;
    out_valid = state == DONE;
    state_nx = (state == IDLE && in_valid) ? BUSY :
               (state == BUSY && count == LAST) ? DONE :
               (state == DONE && out_ready) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      count   <= '0;
      product <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && in_valid) begin
        mcand  <= {8'd0, a};
        mplier <= b;
        acc    <= '0;
        count  <= '0;
      end else if (state == BUSY) begin
        acc    <= sum;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        count  <= count + CW'(1);
        if (count == LAST) product <= sum;
      end
    end
  end
endmodule

// File: tb/tb_shift_add_mult8.sv
// tb_shift_add_mult8: directed vectors with a queue scoreboard and decoupled output monitor
module tb_shift_add_mult8;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 1;
  logic [7:0] a = 0, b = 0;
  logic in_ready, out_valid;
  logic [15:0] product;
  int checks = 0, failures = 0, cyc = 0;
  typedef struct { logic [15:0] exp; int acc_cyc; } item_t;
  item_t sb[$];
  logic prev_ov = 0;
  logic [15:0] held = 0;

  shift_add_mult8 dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .product(product)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, req, $time);
    end
  endtask

  // monitor: pops one expectation per rising out_valid, then watches it stay stable
  always @(negedge clk) begin
    if (!rst_n) prev_ov = 0;
    else begin
      chk("rca_cout", {31'd0, dut.u_rca.cout}, 0);
      if (out_valid) begin
        chk("in_ready_in_done", {31'd0, in_ready}, 0);
        if (!prev_ov) begin
          if (sb.size() == 0) chk("unexpected_result", 1, 0);
          else begin
            item_t e;
            e = sb.pop_front();
            chk("product", {16'd0, product}, {16'd0, e.exp});
            chk("latency", cyc - e.acc_cyc, 8);
            held = product;
          end
        end else chk("product_stable", {16'd0, product}, {16'd0, held});
      end
      prev_ov = out_valid;
    end
  end

  task automatic issue(input logic [7:0] x, input logic [7:0] y, input logic [15:0] exp);
    item_t e;
    int n = 0;
    while (!in_ready && n < 40) begin @(negedge clk); n++; end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    @(negedge clk);
    a = x; b = y; in_valid = 1;
    @(posedge clk);
    #1;
    in_valid = 0;
    e.exp = exp; e.acc_cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic wait_ov();
    int n = 0;
    while (!out_valid && n < 30) begin @(negedge clk); n++; end
    if (!out_valid) chk("out_valid_timeout", 0, 1);
  endtask

  task automatic back_to_idle();
    @(posedge clk);
    #1;
    chk("idle_in_ready", {31'd0, in_ready}, 1);
    chk("idle_out_valid", {31'd0, out_valid}, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_product", {16'd0, product}, 0);
    issue(8, 2, 16);
    wait_ov();
    back_to_idle();
    issue(255, 255, 16'hFE01);
    wait_ov();
    back_to_idle();
    issue(0, 200, 0);
    wait_ov();
    back_to_idle();
    issue(200, 0, 0);
    wait_ov();
    back_to_idle();
    out_ready = 0;
    issue(72, 10, 720);
    wait_ov();
    repeat (5) @(negedge clk);
    chk("bp_product", {16'd0, product}, 720);
    chk("bp_out_valid", {31'd0, out_valid}, 1);
    out_ready = 1;
    back_to_idle();
    issue(3, 5, 15);
    @(negedge clk);
    a = 9; b = 9; in_valid = 1;
    repeat (4) @(negedge clk);
    in_valid = 0;
    wait_ov();
    back_to_idle();
    repeat (12) @(negedge clk);
    chk("no_second_capture", {31'd0, out_valid}, 0);
    issue(100, 100, 10000);
    repeat (4) @(posedge clk);
    #3;
    rst_n = 0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 0);
    chk("midrst_product", {16'd0, product}, 0);
    chk("midrst_in_ready", {31'd0, in_ready}, 1);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1;
    issue(7, 6, 42);
    wait_ov();
    back_to_idle();
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
